// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 4-digit seven-segment scanner.
// Holds the active-low glyph table ({g,f,e,d,c,b,a}, 0 = segment lit),
// the dash/blank glyphs, the blank digit code and the digit count, plus a
// small helper that tells whether a digit code counts as a leading zero.
package seg7_pkg;

  localparam int NDIG = 4;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // A digit is a candidate for leading-zero suppression when it is 0 or blank.
  function automatic logic is_lz_code(input logic [3:0] code);
    return (code == 4'h0) || (code == BLANK_CODE);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 4-bit code to active-low seven-segment glyph.
//   code  in  4  digit code (0-9 digits, A-E dash, F blank)
//   glyph out 7  {g,f,e,d,c,b,a}, active-low
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph
);

  // Glyph lookup; every non-decimal code maps to dash except F, which is blank.
  always_comb begin
    glyph = SEG_BLANK;
    case (code)
      4'h0:    glyph = SEG_0;
      4'h1:    glyph = SEG_1;
      4'h2:    glyph = SEG_2;
      4'h3:    glyph = SEG_3;
      4'h4:    glyph = SEG_4;
      4'h5:    glyph = SEG_5;
      4'h6:    glyph = SEG_6;
      4'h7:    glyph = SEG_7;
      4'h8:    glyph = SEG_8;
      4'h9:    glyph = SEG_9;
      4'hA,
      4'hB,
      4'hC,
      4'hD,
      4'hE:    glyph = SEG_DASH;
      4'hF:    glyph = SEG_BLANK;
      default: glyph = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan4.sv
// seg7_scan4: time-multiplexed driver for a 4-digit common-anode display.
//   clk    in  1  clock
//   rst    in  1  asynchronous active-high reset
//   A..D   in  4  digit codes, A rightmost (digit 0), D leftmost (digit 3)
//   load   in  1  strobe: capture A..D for display from the next frame
//   lz_en  in  1  leading-zero suppression enable
//   seg    out 7  active-low segments {g,f,e,d,c,b,a}, registered
//   an     out 4  active-low digit enables, an[i] = digit i, registered
//   frame  out 1  one-cycle pulse when the scan wraps from digit 3 to 0
// Each digit slot lasts SCAN_DIV clocks; the first clock of a slot is a
// dark guard cycle so the previous digit's segments never ghost onto the
// next anode. New data only reaches the display on a frame wrap, so a
// frame is never a mix of old and new digits.
module seg7_scan4
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  input  logic       load,
  input  logic       lz_en,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic [1:0]    idx_r;
  logic [15:0]   pend_r;
  logic          pend_valid_r;
  logic [15:0]   show_r;

  logic          cnt_last_s;
  logic          wrap_s;
  logic [15:0]   new_digits_s;
  logic          sup3_s;
  logic          sup2_s;
  logic          sup1_s;
  logic [3:0]    sel_code_s;
  logic          sel_sup_s;
  logic [3:0]    an_lit_s;
  logic [6:0]    glyph_s;

  assign cnt_last_s   = (cnt_r == CNT_LAST);
  assign wrap_s       = cnt_last_s && (idx_r == 2'd3);
  assign new_digits_s = {D, C, B, A};

  // Slot prescaler and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
      idx_r <= 2'd0;
    end else if (cnt_last_s) begin
      cnt_r <= {CW{1'b0}};
      idx_r <= idx_r + 2'd1;
    end else begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Pending/shown digit registers; a load on the wrap cycle goes straight to show.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r       <= 16'hFFFF;
      pend_valid_r <= 1'b0;
      show_r       <= 16'hFFFF;
    end else if (wrap_s) begin
      pend_valid_r <= 1'b0;
      if (load) begin
        pend_r <= new_digits_s;
        show_r <= new_digits_s;
      end else if (pend_valid_r) begin
        show_r <= pend_r;
      end else begin
        show_r <= show_r;
      end
    end else if (load) begin
      pend_r       <= new_digits_s;
      pend_valid_r <= 1'b1;
    end else begin
      pend_valid_r <= pend_valid_r;
    end
  end

  // Leading-zero suppression chain from the most significant digit down.
  always_comb begin
    sup3_s = 1'b0;
    sup2_s = 1'b0;
    sup1_s = 1'b0;
    if (lz_en) begin
      sup3_s = is_lz_code(show_r[15:12]);
      sup2_s = sup3_s && is_lz_code(show_r[11:8]);
      sup1_s = sup2_s && is_lz_code(show_r[7:4]);
    end else begin
      sup3_s = 1'b0;
    end
  end

  // Select the current digit's code, suppression flag and anode pattern.
  always_comb begin
    sel_code_s = BLANK_CODE;
    sel_sup_s  = 1'b0;
    an_lit_s   = 4'b1111;
    case (idx_r)
      2'd0: begin
        sel_code_s = show_r[3:0];
        sel_sup_s  = 1'b0;
        an_lit_s   = 4'b1110;
      end
      2'd1: begin
        sel_code_s = show_r[7:4];
        sel_sup_s  = sup1_s;
        an_lit_s   = 4'b1101;
      end
      2'd2: begin
        sel_code_s = show_r[11:8];
        sel_sup_s  = sup2_s;
        an_lit_s   = 4'b1011;
      end
      2'd3: begin
        sel_code_s = show_r[15:12];
        sel_sup_s  = sup3_s;
        an_lit_s   = 4'b0111;
      end
      default: begin
        sel_code_s = BLANK_CODE;
        sel_sup_s  = 1'b1;
        an_lit_s   = 4'b1111;
      end
    endcase
  end

  seg7_decode u_decode (
    .code  (sel_code_s),
    .glyph (glyph_s)
  );

  // Registered display outputs; the first cycle of each slot is a dark guard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an    <= 4'b1111;
      seg   <= SEG_BLANK;
      frame <= 1'b0;
    end else begin
      frame <= wrap_s;
      if (cnt_r == {CW{1'b0}}) begin
        an  <= 4'b1111;
        seg <= SEG_BLANK;
      end else begin
        an  <= an_lit_s;
        seg <= sel_sup_s ? SEG_BLANK : glyph_s;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan4.sv
// tb_seg7_scan4: directed self-checking bench for seg7_scan4 with SCAN_DIV=4.
// A frame is 16 clocks (4 slots x {1 guard + 3 lit}). Outputs are sampled
// 1 time unit after each rising edge; inputs are driven at the same point.
module tb_seg7_scan4;

  logic       clk;
  logic       rst;
  logic [3:0] A, B, C, D;
  logic       load;
  logic       lz_en;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GD = 7'b0111111;
  localparam logic [6:0] GB = 7'b1111111;

  seg7_scan4 #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .load  (load),
    .lz_en (lz_en),
    .seg   (seg),
    .an    (an),
    .frame (frame)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] d, input logic [3:0] c,
                         input logic [3:0] b, input logic [3:0] a);
    D = d; C = c; B = b; A = a;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Advance until the frame pulse is observed (bounded).
  task automatic wait_frame(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (frame === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL %s: frame pulse seen=%0b required=1 within 40 cycles", name, found);
    end
  endtask

  // Called right after a frame pulse: checks the next 16 cycles of output.
  // exp packs {slot3, slot2, slot1, slot0} glyphs.
  task automatic check_frame(input string name, input logic [27:0] exp);
    logic [6:0] eseg;
    logic [3:0] ean;
    logic       efr;
    for (int k = 0; k < 16; k++) begin
      tick();
      if ((k % 4) == 0) begin
        ean  = 4'b1111;
        eseg = 7'b1111111;
      end else begin
        ean  = ~(4'b0001 << (k / 4));
        eseg = exp[(k / 4) * 7 +: 7];
      end
      efr = (k == 15);
      total++;
      if (an !== ean) begin
        bad++;
        $display("FAIL %s an cyc%0d: got=%b want=%b", name, k, an, ean);
      end
      total++;
      if (seg !== eseg) begin
        bad++;
        $display("FAIL %s seg cyc%0d: got=%b want=%b", name, k, seg, eseg);
      end
      total++;
      if (frame !== efr) begin
        bad++;
        $display("FAIL %s frame cyc%0d: got=%b want=%b", name, k, frame, efr);
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (an !== 4'b1111) begin
      bad++;
      $display("FAIL %s an: got=%b want=1111", name, an);
    end
    total++;
    if (seg !== 7'b1111111) begin
      bad++;
      $display("FAIL %s seg: got=%b want=1111111", name, seg);
    end
    total++;
    if (frame !== 1'b0) begin
      bad++;
      $display("FAIL %s frame: got=%b want=0", name, frame);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b0; lz_en = 1'b0;
    A = 4'h0; B = 4'h0; C = 4'h0; D = 4'h0;
    #1 rst = 1'b1;
    #2;
    check_reset_outputs("reset_async_initial");
    tick();
    tick();
    check_reset_outputs("reset_held");
    rst = 1'b0;
    // Blank display until anything is loaded: an scans, seg stays dark.
    wait_frame("reset_first_frame");
    check_frame("reset_idle", {GB, GB, GB, GB});
  endtask

  task automatic test_basic();
    lz_en = 1'b0;
    do_load(4'h0, 4'h1, 4'h2, 4'h3);
    wait_frame("basic_wait");
    check_frame("basic", {G0, G1, G2, G3});
  endtask

  task automatic test_suppress();
    lz_en = 1'b1;
    do_load(4'h0, 4'h0, 4'h0, 4'h0);
    wait_frame("suppress_wait");
    check_frame("suppress_all_zero", {GB, GB, GB, G0});
  endtask

  task automatic test_suppress_stop();
    lz_en = 1'b1;
    do_load(4'h0, 4'h7, 4'h0, 4'h5);
    wait_frame("stop_wait");
    check_frame("suppress_stop", {GB, G7, G0, G5});
  endtask

  task automatic test_last_load();
    lz_en = 1'b0;
    do_load(4'hF, 4'hF, 4'hF, 4'h1);
    tick();
    tick();
    do_load(4'hF, 4'hF, 4'hF, 4'h9);
    wait_frame("last_load_wait");
    check_frame("last_load", {GB, GB, GB, G9});
  endtask

  // Entered right after a frame pulse: 15 clocks later the state is the wrap cycle.
  task automatic test_back_to_back();
    lz_en = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    D = 4'hF; C = 4'hF; B = 4'hF; A = 4'hB;
    load = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if (frame !== 1'b1) begin
      bad++;
      $display("FAIL bypass_frame: got=%b want=1", frame);
    end
    check_frame("bypass_dash", {GB, GB, GB, GD});
  endtask

  task automatic test_reset_mid();
    lz_en = 1'b0;
    do_load(4'h8, 4'h8, 4'h8, 4'h8);
    tick();
    total++;
    if (an !== 4'b1110) begin
      bad++;
      $display("FAIL reset_mid_pre an: got=%b want=1110", an);
    end
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_async");
    tick();
    rst = 1'b0;
    wait_frame("reset_mid_wait");
    check_frame("reset_mid_pend_lost", {GB, GB, GB, GB});
  endtask

  initial begin
    test_reset();
    test_basic();
    test_suppress();
    test_suppress_stop();
    test_last_load();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
